// File: rtl/conv_out_buffer_if.sv
// Handshake bundle between conv_engine's result write port and the
// feature-map readout stream.
interface conv_out_buffer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;

    modport master (
        output wr_en, wr_addr, wr_data, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_out_buffer.sv
// Captures conv_engine results into a feature-map RAM, then streams the map in
// raster order. Define CONV_OUTBUF_RELU_EN to clamp negative results to zero.
//
//   state | meaning
//   IDLE  | waiting for start; writes are illegal
//   FILL  | accepting engine writes until OUTPUT_COUNT are counted
//   DRAIN | streaming addresses 0..OUTPUT_COUNT-1; writes are illegal
module conv_out_buffer #(
    parameter int MAPSIZE = 32,
    parameter int KSIZE   = 5,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    conv_out_buffer_if.slave   bus,
    output logic               fill_done,
    output logic               busy,
    output logic               err
);
    localparam int OUT_DIM      = MAPSIZE - KSIZE + 1;
    localparam int OUTPUT_COUNT = OUT_DIM * OUT_DIM;
    localparam int ADDR_W       = $clog2(OUTPUT_COUNT);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(OUTPUT_COUNT);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(OUTPUT_COUNT - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] mem [OUTPUT_COUNT];
    logic signed [DATA_W-1:0] rd_data, skid_data, out_data_q;
    logic [ADDR_W:0]          wr_count, rd_ptr;
    logic                     rd_pend, rd_last;
    logic                     skid_valid, skid_last;
    logic                     out_valid_q, out_last_q;
    logic                     wr_ok, wr_bad, pop, issue;
    logic [1:0]               occ;

    function automatic logic signed [DATA_W-1:0] post(input logic signed [DATA_W-1:0] x);
`ifdef CONV_OUTBUF_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Slots in flight (output reg + skid + pending RAM read) after this cycle's pop;
    // a read is only issued when it is guaranteed a landing slot.
    always_comb begin
        state_nxt = state;
        wr_ok     = 1'b0;
        wr_bad    = 1'b0;
        pop       = out_valid_q && bus.out_ready;
        occ       = {1'b0, out_valid_q} + {1'b0, skid_valid} + {1'b0, rd_pend} - {1'b0, pop};
        issue     = (state == DRAIN) && (rd_ptr < CNT_FULL) && (occ < 2'd2);
        if (bus.wr_en && !start) begin
            if (state == FILL && {1'b0, bus.wr_addr} < CNT_FULL) wr_ok  = 1'b1;
            else                                                 wr_bad = 1'b1;
        end
        case (state)
            IDLE:    ;
            FILL:    if (wr_ok && wr_count == CNT_LAST) state_nxt = DRAIN;
            DRAIN:   if (pop && out_last_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (start) state_nxt = FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
        if (issue) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            wr_count    <= '0;
            rd_ptr      <= '0;
            rd_pend     <= 1'b0;
            rd_last     <= 1'b0;
            skid_valid  <= 1'b0;
            skid_last   <= 1'b0;
            skid_data   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            fill_done   <= 1'b0;
            err         <= 1'b0;
        end else begin
            fill_done <= wr_ok && (wr_count == CNT_LAST);
            if (wr_ok)  wr_count <= wr_count + 1'b1;
            if (wr_bad) err <= 1'b1;
            rd_pend <= issue;
            if (issue) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_last <= (rd_ptr == CNT_LAST);
            end
            if (!out_valid_q || pop) begin
                if (skid_valid) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= post(skid_data);
                    out_last_q  <= skid_last;
                    skid_valid  <= rd_pend;
                    if (rd_pend) begin
                        skid_data <= rd_data;
                        skid_last <= rd_last;
                    end
                end else if (rd_pend) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= post(rd_data);
                    out_last_q  <= rd_last;
                end else begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_valid <= 1'b1;
                skid_data  <= rd_data;
                skid_last  <= rd_last;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_conv_out_buffer.sv
// Directed bench for conv_out_buffer: fill/drain runs, stalls, illegal writes,
// abort by start and mid-fill reset.
module tb_conv_out_buffer;
    logic clk, rst, start, fill_done, busy, err;
    int   errors = 0;
    int   checks = 0;
    int   fd, beats, cycles, first_v, data_err, last_err, stall_err;

    conv_out_buffer_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    conv_out_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .fill_done (fill_done),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    function automatic logic signed [31:0] exp_val(input int pat, input int a);
        int v;
        v = (pat == 0) ? a - 400 : 1000 - 2 * a;
`ifdef CONV_OUTBUF_RELU_EN
        if (v < 0) v = 0;
`endif
        return v;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic fill(input int pat, input bit rev, input int n, output int fd_cnt);
        int a;
        fd_cnt = 0;
        for (int i = 0; i < n; i++) begin
            a = rev ? 783 - i : i;
            bus.wr_en   = 1'b1;
            bus.wr_addr = a[9:0];
            bus.wr_data = exp_val(pat, a);
`ifdef CONV_OUTBUF_RELU_EN
            bus.wr_data = (pat == 0) ? a - 400 : 1000 - 2 * a;
`endif
            step();
            if (fill_done) fd_cnt++;
        end
        bus.wr_en = 1'b0;
    endtask

    // mode 0: out_ready held high; mode 1: out_ready random each cycle
    task automatic drain(input int pat, input int mode, input int stop,
                         output int nb, output int nc, output int fv,
                         output int de, output int le, output int se);
        bit          pstall, rdy;
        logic [31:0] pdata;
        logic        plast;
        nb = 0; nc = 0; fv = -1; de = 0; le = 0; se = 0;
        pstall = 1'b0; pdata = '0; plast = 1'b0;
        while (busy && nb < stop && nc < 4000) begin
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            if (pstall && (!bus.out_valid || bus.out_data !== pdata || bus.out_last !== plast)) se++;
            if (bus.out_valid) begin
                if (fv < 0) fv = nc;
                if (bus.out_data !== exp_val(pat, nb)) de++;
                if (bus.out_last !== (nb == 783)) le++;
            end
            pstall = bus.out_valid && !rdy;
            pdata  = bus.out_data;
            plast  = bus.out_last;
            if (bus.out_valid && rdy) nb++;
            step();
            nc++;
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last",  bus.out_last,  0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_fill_done", fill_done,     0);
        chk("rst_busy",      busy,          0);
        chk("rst_err",       err,           0);
        rst = 1'b0;
        step();

        // Run A: baseline, with a write coinciding with start
        bus.wr_en = 1'b1; bus.wr_addr = 10'd0; bus.wr_data = 32'd77;
        start = 1'b1;
        step();
        start = 1'b0; bus.wr_en = 1'b0;
        chk("a_busy_after_start", busy, 1);
        chk("a_err_start_write",  err,  0);
        fill(0, 1'b0, 784, fd);
        chk("a_fill_done_count", fd, 1);
        chk("a_fill_done_now",   fill_done, 1);
        drain(0, 0, 100000, beats, cycles, first_v, data_err, last_err, stall_err);
        chk("a_beats",     beats,    784);
        chk("a_first_vld", first_v,  2);
        chk("a_cycles",    cycles,   786);
        chk("a_data",      data_err, 0);
        chk("a_last",      last_err, 0);
        chk("a_err",       err,      0);
        chk("a_idle_vld",  bus.out_valid, 0);

        // Run B: reverse-order fill
        pulse_start();
        fill(0, 1'b1, 784, fd);
        chk("b_fill_done_count", fd, 1);
        drain(0, 0, 100000, beats, cycles, first_v, data_err, last_err, stall_err);
        chk("b_beats",  beats,    784);
        chk("b_cycles", cycles,   786);
        chk("b_data",   data_err, 0);
        chk("b_last",   last_err, 0);

        // Run C: random backpressure
        pulse_start();
        fill(0, 1'b0, 784, fd);
        drain(0, 1, 100000, beats, cycles, first_v, data_err, last_err, stall_err);
        chk("c_beats", beats,     784);
        chk("c_data",  data_err,  0);
        chk("c_last",  last_err,  0);
        chk("c_stall", stall_err, 0);
        chk("c_busy",  busy,      0);

        // Run D: illegal writes in FILL and DRAIN
        pulse_start();
        bus.wr_en = 1'b1; bus.wr_addr = 10'd784; bus.wr_data = 32'd5;
        step();
        bus.wr_en = 1'b0;
        chk("d_err_oob",      err,       1);
        chk("d_no_fill_done", fill_done, 0);
        fill(0, 1'b0, 784, fd);
        chk("d_fill_done_count", fd, 1);
        chk("d_fill_done_now",   fill_done, 1);
        bus.wr_en = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = 32'd12345;
        step();
        bus.wr_en = 1'b0;
        chk("d_err_drain_write", err, 1);
        drain(0, 0, 100000, beats, cycles, first_v, data_err, last_err, stall_err);
        chk("d_beats",      beats,    784);
        chk("d_data",       data_err, 0);
        chk("d_err_sticky", err,      1);

        // Run E: abort during DRAIN, then refill with new data
        pulse_start();
        chk("e_err_cleared", err, 0);
        fill(0, 1'b0, 784, fd);
        drain(0, 0, 301, beats, cycles, first_v, data_err, last_err, stall_err);
        chk("e_partial_beats", beats,    301);
        chk("e_partial_data",  data_err, 0);
        pulse_start();
        chk("e_abort_valid", bus.out_valid, 0);
        chk("e_abort_busy",  busy,          1);
        fill(1, 1'b0, 784, fd);
        chk("e_fill_done_count", fd, 1);
        drain(1, 0, 100000, beats, cycles, first_v, data_err, last_err, stall_err);
        chk("e_beats",  beats,    784);
        chk("e_cycles", cycles,   786);
        chk("e_data",   data_err, 0);
        chk("e_last",   last_err, 0);

        // Run F: reset mid-fill, then a full run
        pulse_start();
        bus.wr_en = 1'b1; bus.wr_addr = 10'd1000; bus.wr_data = 32'd1;
        step();
        bus.wr_en = 1'b0;
        fill(0, 1'b0, 500, fd);
        chk("f_partial_fd", fd,  0);
        chk("f_err_before", err, 1);
        rst = 1'b1;
        step();
        chk("f_rst_out_valid", bus.out_valid, 0);
        chk("f_rst_out_last",  bus.out_last,  0);
        chk("f_rst_out_data",  bus.out_data,  0);
        chk("f_rst_fill_done", fill_done,     0);
        chk("f_rst_busy",      busy,          0);
        chk("f_rst_err",       err,           0);
        rst = 1'b0;
        step();
        pulse_start();
        fill(1, 1'b1, 784, fd);
        chk("f_fill_done_count", fd, 1);
        drain(1, 1, 100000, beats, cycles, first_v, data_err, last_err, stall_err);
        chk("f_beats", beats,     784);
        chk("f_data",  data_err,  0);
        chk("f_last",  last_err,  0);
        chk("f_stall", stall_err, 0);
        chk("f_err",   err,       0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv_out_buffer.md
# conv_out_buffer

Output-side receiver for `conv_engine`. It captures the engine's result write port (`mem_wr_en` / `mem_wr_addr` / `mem_wr_data`) into an on-chip feature-map RAM and counts completed writes. Once the full map is present, it streams the map out in raster order over a valid/ready interface. It sits between `conv_engine` and the downstream layer or host readout, in place of the golden-compare path used for bring-up.

## Interface
Parameters:
- `MAPSIZE`, 32, input feature-map edge length.
- `KSIZE`, 5, convolution kernel edge length.
- `DATA_W`, 32, signed result width.
- Derived, not overridable: `OUT_DIM = MAPSIZE-KSIZE+1` (28), `OUTPUT_COUNT = OUT_DIM*OUT_DIM` (784), `ADDR_W = $clog2(OUTPUT_COUNT)` (10).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; clears counters and error, enters FILL.
- `wr_en`  in  1  engine result write strobe.
- `wr_addr`  in  `ADDR_W`  engine result address.
- `wr_data`  in  `DATA_W`  signed engine result.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  `DATA_W`  signed output beat.
- `out_last`  out  1  high on the beat with address `OUTPUT_COUNT-1`.
- `fill_done`  out  1  one-cycle pulse when the write count reaches `OUTPUT_COUNT`.
- `busy`  out  1  high in FILL and DRAIN.
- `err`  out  1  sticky; set by an illegal write.

## Operation
- States:
  - IDLE → FILL on `start`.
  - FILL → DRAIN when `wr_count == OUTPUT_COUNT`.
  - DRAIN → IDLE when the `out_last` beat is accepted.
- `start` in any state, including FILL and DRAIN, aborts the current operation. The block clears `wr_count`, the read pointer, the output pipeline, and `err`, then enters FILL. RAM contents are not cleared.
- FILL behaviour:
  - A write with `wr_en` and `wr_addr < OUTPUT_COUNT` stores `wr_data` at `wr_addr` and increments `wr_count` (width `ADDR_W+1`).
  - A write with `wr_addr >= OUTPUT_COUNT` is dropped, does not count, and sets `err`.
  - Duplicate addresses are counted. The engine guarantees each address is written exactly once.
- `wr_en` in IDLE or DRAIN is dropped and sets `err`.
- DRAIN reads addresses 0..`OUTPUT_COUNT-1` in order. RAM reads are synchronous with 1-cycle latency. A 2-entry skid/prefetch stage decouples the read from `out_ready`.
- Handshake rules:
  - A beat transfers when `out_valid && out_ready`.
  - While `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
  - `out_valid` never drops without a transfer.
- `out_data` is `wr_data` unchanged, or ReLU-clamped when configured (see Configuration).

## Timing
- Reset values:
  - State IDLE.
  - `out_valid`, `out_last`, `fill_done`, `busy`, `err` all 0.
  - `out_data` 0.
  - Counters 0.
- `busy` rises the cycle after `start`.
- `fill_done` pulses in the cycle after the write that makes the count `OUTPUT_COUNT`. DRAIN is entered in that same cycle.
- First `out_valid` appears 2 cycles after entering DRAIN.
- With `out_ready` held high, throughput is 1 beat/cycle with no bubbles. The drain takes `OUTPUT_COUNT+2` cycles from DRAIN entry to the IDLE return.
- `out_ready` deassertion stalls with zero beat loss and zero duplication, at any cycle including the prefetch edge.
- `busy` falls the cycle after the `out_last` transfer.
- A `wr_en` arriving in the same cycle as `start` is ignored, and no error is raised.

## Configuration
- `CONV_OUTBUF_RELU_EN`:
  - Defined: `out_data = (x < 0) ? 0 : x`, applied at the output register.
  - Undefined: signed pass-through of the stored value.
- Storage and latency are identical in both builds.

## Test plan
- Reset, `start`, 784 writes at addresses 0..783 with `data = addr-400`, `out_ready=1` → `fill_done` pulses once; 784 beats appear consecutively with `out_data = addr-400` (or `max(0, addr-400)` under `CONV_OUTBUF_RELU_EN`); `out_last` appears only on beat 783; `err=0`.
- Same fill with writes in reverse address order → output is still in raster order 0..783 with identical values.
- Drain with `out_ready` toggling pseudo-randomly (~50%) → exactly 784 beats in order, no duplicates; `out_data` is stable during every stall.
- Write to `wr_addr=784` during FILL, and a write during DRAIN → `err=1` and stays 1; `wr_count` is unchanged; the drain output is unaffected.
- `start` asserted midway through DRAIN (after beat 300) → `out_valid` drops the next cycle and `busy` stays 1; a fresh 784-write fill drains the new data correctly.
- `rst` asserted mid-FILL (after 500 writes) → all outputs return to reset values on the next edge; a subsequent full run passes.
